fifo_read_arbiter: RTL and testbench
====================================

# fifo_read_arbiter

Round-robin read-side scheduler that drains up to NUM_FIFOS asynchronous FIFOs sharing one read clock and merges them onto a single valid/ready output stream. It sits in the RClk domain and drives each FIFO's ReadEn_in from that FIFO's Empty_out. It captures the FIFO Data_out one cycle after each read and buffers words in a 2-entry output queue. Each word is tagged with its source index so downstream logic can demultiplex.

## Interface
- DATA_WIDTH, 32, width of every FIFO word and of Data_out
- NUM_FIFOS, 4, number of FIFOs arbitrated (2..16)
- BURST_MAX, 4, maximum consecutive reads granted to one FIFO before rotating (1..15)
- SRC_W, $clog2(NUM_FIFOS), width of source tag

- RClk  in  1  read clock, shared with all arbitrated FIFO read ports
- PresetFull  in  1  reset PresetFull, asynchronous, active-high; clock RClk
- Enable_in  in  1  1 = new reads may be issued; 0 = drain in-flight reads only
- Empty_in  in  NUM_FIFOS  Empty_out of FIFO i on bit i
- FifoData_in  in  NUM_FIFOS*DATA_WIDTH  Data_out of FIFO i on bits [i*DATA_WIDTH +: DATA_WIDTH]
- ReadEn_out  out  NUM_FIFOS  one-hot (or zero) ReadEn_in to FIFO i
- Data_out  out  DATA_WIDTH  head word of output queue
- Src_out  out  SRC_W  source FIFO index of Data_out
- Valid_out  out  1  output queue non-empty
- Ready_in  in  1  downstream accepts head word when Valid_out & Ready_in at RClk edge
- Busy_out  out  1  state != IDLE or read in flight

## Operation
- States: IDLE, GRANT, ROTATE.
- IDLE: if Enable_in and any Empty_in bit low, pick first non-empty FIFO scanning from rr_ptr upward (wrapping at NUM_FIFOS-1 -> 0), load grant index, clear burst count, go GRANT.
- GRANT: ReadEn_out[grant] = Enable_in & ~Empty_in[grant] & (credit < 2). ReadEn_out is combinational from registered state and inputs. Burst count increments per issued read. Go ROTATE when burst count reaches BURST_MAX, Empty_in[grant] = 1, or Enable_in = 0.
- ROTATE: rr_ptr <= grant+1 (wrap), then IDLE. Takes one cycle; no read is issued.
- Credit = words in output queue + reads in flight (0..2). A read is issued only if credit < 2, so the queue never overflows.
- In-flight tracking: one-cycle pipe register (inflight_v, inflight_src). Set on the edge where a read is issued. On the next edge, FifoData_in[inflight_src] is written to the queue tail with tag inflight_src.
- Queue: 2-entry FIFO, in-order. Head drives Data_out/Src_out; Valid_out = count != 0.
- Simultaneous push and pop: count unchanged, order preserved. Pop with empty queue is ignored (Valid_out low).
- Only one ReadEn_out bit is ever high. No FIFO is read while its Empty_in is high.
- Enable_in low mid-burst: no further reads. The in-flight word still lands in the queue. FSM goes ROTATE -> IDLE.

## Timing
- Reset (PresetFull high, asynchronous): state IDLE, rr_ptr 0, inflight_v 0, queue count 0. Outputs: ReadEn_out 0, Valid_out 0, Data_out 0, Src_out 0, Busy_out 0. Release is sampled on the next RClk edge.
- Reset during an in-flight read: the word popped from the FIFO is discarded (documented loss).
- Latency: read issued in cycle N (edge N samples ReadEn) -> FIFO Data_out valid after edge N -> queued at edge N+1 -> Valid_out high in cycle N+1.
- IDLE -> first ReadEn: 1 cycle after a non-empty Empty_in is seen. Burst rotation overhead: 2 cycles (ROTATE + IDLE).
- Sustained throughput with Ready_in = 1: 1 word/cycle within a burst (credit returns via the same-cycle pop).
- Empty_in is not registered here. It must be stable in RClk, which holds because the FIFO Empty flag is RClk-synchronous apart from its asynchronous preset-to-1, which only blocks reads.

## Test plan
- Reset: hold PresetFull for 3 cycles with all FIFOs holding data -> all outputs 0, no ReadEn_out. Release -> ReadEn_out = 4'b0001 within 2 cycles.
- Round robin: FIFOs 0..3 each preloaded with 8 words (value = 16*i + k), BURST_MAX = 4, Ready_in = 1 -> Src_out sequence 0,0,0,0,1,1,1,1,2,...,3, then 0 again. Values are in order per source; 32 words total.
- Backpressure: Ready_in = 0 with FIFO 2 non-empty -> exactly 2 reads issued, Valid_out = 1, Data_out holds the first word. Ready_in = 1 then resumes with no loss or duplication.
- Empty mid-burst: FIFO 1 holds 2 words, FIFO 3 holds 5 -> 2 reads from FIFO 1, rotate, 4 from FIFO 3, rotate, FIFO 3's last word. ReadEn_out is never high while the matching Empty_in is high.
- Enable_in drop: deassert Enable_in in the cycle after a read issues -> that word still appears on Data_out, no further ReadEn_out, FSM returns to IDLE, Busy_out = 0 after the queue drains.
- Reset mid-read: assert PresetFull in the cycle after a ReadEn_out pulse -> Valid_out 0, queue empty. After release, arbitration restarts at FIFO 0.

Source files
------------

// File: rtl/fifo_read_arbiter.sv
// rtl/fifo_read_arbiter.sv - round-robin read scheduler merging several FIFOs onto one valid/ready stream
//
// Drains up to NUM_FIFOS FIFOs that share the read clock RClk. A FIFO is granted
// for a burst of up to BURST_MAX reads, and then the grant rotates to the next index.
// Each read word is captured one cycle after its ReadEn pulse, tagged with its source
// index, and stored in a 2-entry output queue.
//
// Ports:
//   RClk        read clock shared with all FIFO read ports
//   PresetFull  asynchronous active-high reset
//   Enable_in   1 = new reads may be issued, 0 = only in-flight reads complete
//   Empty_in    Empty_out of FIFO i on bit i
//   FifoData_in Data_out of FIFO i on bits [i*DATA_WIDTH +: DATA_WIDTH]
//   ReadEn_out  one-hot (or zero) read enable to FIFO i
//   Data_out    head word of the output queue
//   Src_out     source FIFO index of Data_out
//   Valid_out   output queue non-empty
//   Ready_in    downstream takes the head word when Valid_out & Ready_in at an RClk edge
//   Busy_out    scheduler not idle, or a read is in flight

module fifo_read_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_FIFOS  = 4,
    parameter int BURST_MAX  = 4,
    parameter int SRC_W      = $clog2(NUM_FIFOS)
) (
    input  logic                            RClk,
    input  logic                            PresetFull,
    input  logic                            Enable_in,
    input  logic [NUM_FIFOS-1:0]            Empty_in,
    input  logic [NUM_FIFOS*DATA_WIDTH-1:0] FifoData_in,
    output logic [NUM_FIFOS-1:0]            ReadEn_out,
    output logic [DATA_WIDTH-1:0]           Data_out,
    output logic [SRC_W-1:0]                Src_out,
    output logic                            Valid_out,
    input  logic                            Ready_in,
    output logic                            Busy_out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1,
        S_ROTATE = 2'd2
    } state_t;

    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SRC_W-1:0]      r_rr_ptr;
    logic [SRC_W-1:0]      w_rr_ptr_nxt;
    logic [SRC_W-1:0]      r_grant;
    logic [SRC_W-1:0]      w_grant_nxt;
    logic [3:0]            r_burst;
    logic [3:0]            w_burst_nxt;

    logic                  r_inflight_v;
    logic [SRC_W-1:0]      r_inflight_src;

    logic [DATA_WIDTH-1:0] r_q_data [2];
    logic [SRC_W-1:0]      r_q_src  [2];
    logic                  r_q_head;
    logic [1:0]            r_q_count;

    logic                  w_pop;
    logic                  w_issue;
    logic                  w_tail;
    logic [1:0]            w_credit;
    logic                  w_pick_valid;
    logic [SRC_W-1:0]      w_pick_idx;
    logic [SRC_W:0]        w_scan;
    logic [DATA_WIDTH-1:0] w_fifo_word [NUM_FIFOS];

    assign Valid_out = (r_q_count != 2'd0);
    assign Data_out  = r_q_data[r_q_head];
    assign Src_out   = r_q_src[r_q_head];
    assign Busy_out  = (r_state != S_IDLE) | r_inflight_v;

    assign w_pop = Valid_out & Ready_in;
    // A pop in this cycle frees a slot at the same edge. Counting it here
    // lets a burst sustain one word per cycle while Ready_in stays high.
    assign w_credit = r_q_count + {1'b0, r_inflight_v} - {1'b0, w_pop};
    assign w_issue  = (r_state == S_GRANT) & Enable_in & ~Empty_in[r_grant] & (w_credit < 2'd2);
    assign w_tail   = r_q_head ^ r_q_count[0];

    always_comb begin
        for (int i = 0; i < NUM_FIFOS; i++) begin
            w_fifo_word[i] = FifoData_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        ReadEn_out          = '0;
        ReadEn_out[r_grant] = w_issue;
    end

    // Find the first non-empty FIFO at or after r_rr_ptr. The scan walks downward,
    // so the smallest offset is the last one written and wins.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_idx   = '0;
        w_scan       = '0;
        for (int k = NUM_FIFOS - 1; k >= 0; k--) begin
            w_scan = {1'b0, r_rr_ptr} + (SRC_W+1)'(k);
            if (w_scan >= (SRC_W+1)'(NUM_FIFOS)) begin
                w_scan = w_scan - (SRC_W+1)'(NUM_FIFOS);
            end
            if (!Empty_in[w_scan[SRC_W-1:0]]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = w_scan[SRC_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_burst_nxt  = r_burst;
        w_rr_ptr_nxt = r_rr_ptr;
        case (r_state)
            S_IDLE: begin
                if (Enable_in && w_pick_valid) begin
                    w_grant_nxt = w_pick_idx;
                    w_burst_nxt = '0;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (w_issue) begin
                    w_burst_nxt = r_burst + 4'd1;
                end
                if ((w_issue && (r_burst + 4'd1 == BURST_LIM)) || Empty_in[r_grant] || !Enable_in) begin
                    w_state_nxt = S_ROTATE;
                end
            end
            S_ROTATE: begin
                w_rr_ptr_nxt = (r_grant == SRC_W'(NUM_FIFOS - 1)) ? '0 : r_grant + SRC_W'(1);
                w_state_nxt  = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge RClk or posedge PresetFull) begin
        if (PresetFull) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_burst  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_grant  <= w_grant_nxt;
            r_burst  <= w_burst_nxt;
        end
    end

    // A read issued on one edge lands in the queue on the next edge. If reset
    // arrives in between, that word is dropped.
    always_ff @(posedge RClk or posedge PresetFull) begin
        if (PresetFull) begin
            r_inflight_v   <= 1'b0;
            r_inflight_src <= '0;
            r_q_head       <= 1'b0;
            r_q_count      <= 2'd0;
            r_q_data[0]    <= '0;
            r_q_data[1]    <= '0;
            r_q_src[0]     <= '0;
            r_q_src[1]     <= '0;
        end else begin
            r_inflight_v <= w_issue;
            if (w_issue) begin
                r_inflight_src <= r_grant;
            end
            if (r_inflight_v) begin
                r_q_data[w_tail] <= w_fifo_word[r_inflight_src];
                r_q_src[w_tail]  <= r_inflight_src;
            end
            if (w_pop) begin
                r_q_head <= ~r_q_head;
            end
            r_q_count <= r_q_count + {1'b0, r_inflight_v} - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// tb/tb_fifo_read_arbiter.sv - scoreboard bench for fifo_read_arbiter with FIFO and round-robin reference models

module tb_fifo_read_arbiter;

    localparam int DW = 32;
    localparam int NF = 4;
    localparam int BM = 4;
    localparam int SW = 2;

    logic          RClk = 1'b0;
    logic          PresetFull;
    logic          Enable_in;
    logic          Ready_in;
    logic [NF-1:0] Empty_in;
    logic [NF-1:0] ReadEn_out;
    logic [NF*DW-1:0] FifoData_in;
    logic [DW-1:0] Data_out;
    logic [SW-1:0] Src_out;
    logic          Valid_out;
    logic          Busy_out;

    int total = 0;
    int bad   = 0;
    int rd_total = 0;
    logic [NF-1:0] rd_cap = '0;

    logic [DW-1:0] fifo_q [NF][$];
    logic [DW-1:0] m_q    [NF][$];
    int            m_ptr = 0;
    logic [DW-1:0] exp_data [$];
    logic [SW-1:0] exp_src  [$];
    logic [DW-1:0] mon_d;
    logic [SW-1:0] mon_s;

    fifo_read_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_FIFOS  (NF),
        .BURST_MAX  (BM)
    ) dut (
        .RClk        (RClk),
        .PresetFull  (PresetFull),
        .Enable_in   (Enable_in),
        .Empty_in    (Empty_in),
        .FifoData_in (FifoData_in),
        .ReadEn_out  (ReadEn_out),
        .Data_out    (Data_out),
        .Src_out     (Src_out),
        .Valid_out   (Valid_out),
        .Ready_in    (Ready_in),
        .Busy_out    (Busy_out)
    );

    always #5 RClk = ~RClk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic refresh_empty();
        for (int i = 0; i < NF; i++) Empty_in[i] = (fifo_q[i].size() == 0);
    endtask

    task automatic load(input int i, input logic [DW-1:0] w);
        fifo_q[i].push_back(w);
        m_q[i].push_back(w);
        refresh_empty();
    endtask

    function automatic bit fifos_empty();
        for (int i = 0; i < NF; i++) if (fifo_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Reference order: visit non-empty FIFOs round-robin from m_ptr, take up to BM words each
    task automatic model_drain();
        int src;
        while (1) begin
            src = -1;
            for (int k = 0; k < NF; k++) begin
                if (src < 0 && m_q[(m_ptr + k) % NF].size() > 0) src = (m_ptr + k) % NF;
            end
            if (src < 0) break;
            for (int b = 0; b < BM && m_q[src].size() > 0; b++) begin
                exp_data.push_back(m_q[src].pop_front());
                exp_src.push_back(SW'(src));
            end
            m_ptr = (src + 1) % NF;
        end
    endtask

    // One RClk cycle: sample ReadEn before the edge, then model the FIFO pop after it
    task automatic cycle();
        @(negedge RClk);
        rd_cap = ReadEn_out;
        check("rden_onehot", {63'd0, $onehot0(rd_cap)}, 64'd1);
        check("rden_on_empty", rd_cap & Empty_in, 0);
        rd_total += $countones(rd_cap);
        @(posedge RClk);
        #1;
        for (int i = 0; i < NF; i++) begin
            if (rd_cap[i] && fifo_q[i].size() > 0) FifoData_in[i*DW +: DW] = fifo_q[i].pop_front();
        end
        refresh_empty();
    endtask

    task automatic drain(input bit rand_ready);
        int n = 0;
        while (n < 3000 && !(exp_src.size() == 0 && fifos_empty() && !Busy_out && !Valid_out)) begin
            if (rand_ready) Ready_in = ($urandom_range(0, 3) != 0);
            cycle();
            n++;
        end
        check("drain_in_budget", {63'd0, n < 3000}, 64'd1);
        check("drain_exp_left", exp_src.size(), 0);
        Ready_in = 1'b1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rden"},  ReadEn_out, 0);
        check({tag, "_valid"}, Valid_out, 0);
        check({tag, "_data"},  Data_out, 0);
        check({tag, "_src"},   Src_out, 0);
        check({tag, "_busy"},  Busy_out, 0);
    endtask

    always @(negedge RClk) begin
        if (!PresetFull && Valid_out && Ready_in) begin
            if (exp_src.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_word: got src %0d data %0h want none", Src_out, Data_out);
            end else begin
                mon_s = exp_src.pop_front();
                mon_d = exp_data.pop_front();
                check("out_src", Src_out, mon_s);
                check("out_data", Data_out, mon_d);
            end
        end
    end

    initial begin
        int n;
        int rd0;
        PresetFull  = 1'b1;
        Enable_in   = 1'b1;
        Ready_in    = 1'b1;
        FifoData_in = '0;
        refresh_empty();

        // Reset held with every FIFO holding data, then round robin with Ready high
        for (int i = 0; i < NF; i++) for (int k = 0; k < 8; k++) load(i, DW'(16 * i + k));
        model_drain();
        for (int c = 0; c < 3; c++) begin
            cycle();
            check_zero_outputs("reset");
        end
        PresetFull = 1'b0;
        n = 0;
        do begin cycle(); n++; end while (rd_cap == 0 && n < 3);
        check("first_grant", rd_cap, 4'b0001);
        drain(1'b0);

        // Backpressure: only two reads may be outstanding
        Ready_in = 1'b0;
        for (int k = 0; k < 5; k++) load(2, $urandom());
        model_drain();
        rd0 = rd_total;
        repeat (10) cycle();
        check("bp_reads", rd_total - rd0, 2);
        check("bp_valid", Valid_out, 1);
        check("bp_data", Data_out, exp_data.size() > 0 ? exp_data[0] : 'x);
        check("bp_src", Src_out, exp_src.size() > 0 ? exp_src[0] : 'x);
        drain(1'b1);

        // FIFO runs empty mid-burst
        for (int k = 0; k < 2; k++) load(1, $urandom());
        for (int k = 0; k < 5; k++) load(3, $urandom());
        model_drain();
        drain(1'b1);

        // Enable drop right after a read issues
        for (int k = 0; k < 3; k++) load(2, $urandom());
        n = 0;
        do begin cycle(); n++; end while (rd_cap == 0 && n < 6);
        check("en_first_read", rd_cap, 4'b0100);
        Enable_in = 1'b0;
        exp_data.push_back(m_q[2].pop_front());
        exp_src.push_back(SW'(2));
        m_ptr = 3;
        rd0 = rd_total;
        repeat (8) cycle();
        check("en_no_reads", rd_total - rd0, 0);
        check("en_busy", Busy_out, 0);
        check("en_valid", Valid_out, 0);
        check("en_word_seen", exp_src.size(), 0);
        Enable_in = 1'b1;
        model_drain();
        drain(1'b1);

        // Randomized rounds
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NF; i++) begin
                n = $urandom_range(0, 9);
                for (int k = 0; k < n; k++) load(i, $urandom());
            end
            model_drain();
            drain(1'b1);
        end

        // Reset during an in-flight read: the word is lost and arbitration restarts at FIFO 0
        Ready_in = 1'b0;
        for (int k = 0; k < 3; k++) load(1, DW'(32'hA000 + k));
        n = 0;
        do begin cycle(); n++; end while (rd_cap == 0 && n < 6);
        check("rst_read_seen", rd_cap, 4'b0010);
        PresetFull = 1'b1;
        void'(m_q[1].pop_front());
        m_ptr = 0;
        exp_data.delete();
        exp_src.delete();
        #1;
        check_zero_outputs("midrst");
        for (int k = 0; k < 2; k++) load(0, DW'(32'hB000 + k));
        repeat (2) cycle();
        check("midrst_queue", Valid_out, 0);
        PresetFull = 1'b0;
        Ready_in = 1'b1;
        model_drain();
        n = 0;
        do begin cycle(); n++; end while (rd_cap == 0 && n < 4);
        check("restart_fifo0", rd_cap, 4'b0001);
        drain(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
